// File: rtl/fp_compare_unit.sv
// ============================================================================
// Module      : fp_compare_unit
// Description : Multi-cycle IEEE-754 single-precision FLE/FLT/FEQ comparator.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fp_compare_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_start,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_op_a,
   input  logic [31:0] i_op_b,
   output logic [31:0] o_r,
   output logic        o_nv,
   output logic        o_busy,
   output logic        o_done
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CLASSIFY = 2'd1;
   localparam logic [1:0] S_COMPARE  = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   localparam logic [2:0] F_FLE = 3'b000;
   localparam logic [2:0] F_FLT = 3'b001;
   localparam logic [2:0] F_FEQ = 3'b010;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;

   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [2:0]  r_funct3;
   logic        r_a_nan, r_a_snan, r_a_zero;
   logic        r_b_nan, r_b_snan, r_b_zero;
   logic        r_res;
   logic        r_nv;

   logic        w_accept;
   logic        w_any_nan;
   logic        w_any_snan;
   logic        w_both_zero;
   logic        w_eq;
   logic        w_lt;
   logic        w_res;
   logic        w_nv;

   assign w_accept = (r_state == S_IDLE) && i_start;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:     w_next_state = i_start ? S_CLASSIFY : S_IDLE;
         S_CLASSIFY: w_next_state = S_COMPARE;
         S_COMPARE:  w_next_state = S_DONE;
         S_DONE:     w_next_state = S_IDLE;
         default:    w_next_state = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      o_busy = 1'b0;
      o_done = 1'b0;
      case (r_state)
         S_CLASSIFY: o_busy = 1'b1;
         S_COMPARE:  o_busy = 1'b1;
         S_DONE: begin
            o_busy = 1'b1;
            o_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
            o_done = 1'b0;
         end
      endcase
   end

   assign w_any_nan   = r_a_nan  | r_b_nan;
   assign w_any_snan  = r_a_snan | r_b_snan;
   assign w_both_zero = r_a_zero & r_b_zero;
   assign w_eq        = (r_op_a == r_op_b) | w_both_zero;

   // Sign-magnitude ordering; the two zeros are never less than each other.
   always_comb begin
      w_lt = 1'b0;
      if (!w_both_zero) begin
         if (r_op_a[31] != r_op_b[31]) begin
            w_lt = r_op_a[31];
         end else if (!r_op_a[31]) begin
            w_lt = (r_op_a[30:0] < r_op_b[30:0]);
         end else begin
            w_lt = (r_op_a[30:0] > r_op_b[30:0]);
         end
      end
   end

   always_comb begin
      w_res = 1'b0;
      w_nv  = 1'b0;
      case (r_funct3)
         F_FLE: begin
            w_res = ~w_any_nan & (w_lt | w_eq);
            w_nv  = w_any_nan;
         end
         F_FLT: begin
            w_res = ~w_any_nan & w_lt;
            w_nv  = w_any_nan;
         end
         F_FEQ: begin
            w_res = ~w_any_nan & w_eq;
            w_nv  = w_any_snan;
         end
         default: begin
            w_res = 1'b0;
            w_nv  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op_a   <= 32'd0;
         r_op_b   <= 32'd0;
         r_funct3 <= 3'd0;
         r_a_nan  <= 1'b0;
         r_a_snan <= 1'b0;
         r_a_zero <= 1'b0;
         r_b_nan  <= 1'b0;
         r_b_snan <= 1'b0;
         r_b_zero <= 1'b0;
         r_res    <= 1'b0;
         r_nv     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a   <= i_op_a;
            r_op_b   <= i_op_b;
            r_funct3 <= i_funct3;
         end
         if (r_state == S_CLASSIFY) begin
            r_a_nan  <= (&r_op_a[30:23]) && (|r_op_a[22:0]);
            r_a_snan <= (&r_op_a[30:23]) && (|r_op_a[22:0]) && !r_op_a[22];
            r_a_zero <= (r_op_a[30:0] == 31'd0);
            r_b_nan  <= (&r_op_b[30:23]) && (|r_op_b[22:0]);
            r_b_snan <= (&r_op_b[30:23]) && (|r_op_b[22:0]) && !r_op_b[22];
            r_b_zero <= (r_op_b[30:0] == 31'd0);
         end
         if (r_state == S_COMPARE) begin
            r_res <= w_res;
            r_nv  <= w_nv;
         end
      end
   end

   assign o_r  = {31'd0, r_res};
   assign o_nv = r_nv;

endmodule

`default_nettype wire

// File: tb/tb_fp_compare_unit.sv
// ============================================================================
// Module      : tb_fp_compare_unit
// Description : Directed and random checks of fp_compare_unit against a real-valued model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fp_compare_unit;

   logic        clk;
   logic        rst_n;
   logic        i_start;
   logic [2:0]  i_funct3;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic [31:0] o_r;
   logic        o_nv;
   logic        o_busy;
   logic        o_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] pool [16] = '{
      32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
      32'h40000000, 32'hC0000000, 32'h7F800000, 32'hFF800000,
      32'h7FC00000, 32'hFFC00000, 32'h7F800001, 32'hFFA00000,
      32'h00000001, 32'h80000001, 32'h7F7FFFFF, 32'hFF7FFFFF};

   fp_compare_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (i_start),
      .i_funct3 (i_funct3),
      .i_op_a   (i_op_a),
      .i_op_b   (i_op_b),
      .o_r      (o_r),
      .o_nv     (o_nv),
      .o_busy   (o_busy),
      .o_done   (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Numeric value of the encoding; infinities map to values beyond any finite float.
   function automatic real to_real(input logic [31:0] x);
      real mag;
      int  e;
      e = int'(x[30:23]);
      if (e == 255)
         mag = 1.0e300;
      else if (e == 0)
         mag = real'(x[22:0]) * (2.0 ** (-149.0));
      else
         mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
      return x[31] ? -mag : mag;
   endfunction

   function automatic bit is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 0);
   endfunction

   function automatic bit is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction

   task automatic model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] er, output logic env);
      real ra, rb;
      bit  nan, snan;
      ra   = to_real(a);
      rb   = to_real(b);
      nan  = is_nan(a) || is_nan(b);
      snan = is_snan(a) || is_snan(b);
      er   = 32'd0;
      env  = 1'b0;
      case (f)
         3'd0: begin er = (!nan && ra <= rb) ? 32'd1 : 32'd0; env = nan;  end
         3'd1: begin er = (!nan && ra <  rb) ? 32'd1 : 32'd0; env = nan;  end
         3'd2: begin er = (!nan && ra == rb) ? 32'd1 : 32'd0; env = snan; end
         default: begin er = 32'd0; env = 1'b0; end
      endcase
   endtask

   // One operation: drive at a falling edge, accept on the next rising edge,
   // then expect BUSY for three cycles with DONE and the result in the third.
   // hold=1 keeps START high throughout (streaming); hold=0 pokes START while busy.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit hold);
      logic [31:0] er;
      logic        env;
      model(f, a, b, er, env);
      @(negedge clk);
      check({tag, ".idle_busy"}, {31'd0, o_busy}, 32'd0);
      check({tag, ".idle_done"}, {31'd0, o_done}, 32'd0);
      i_start  = 1'b1;
      i_funct3 = f;
      i_op_a   = a;
      i_op_b   = b;
      @(posedge clk);
      #1;
      if (!hold) i_start = 1'b0;
      i_op_a   = $urandom;
      i_op_b   = $urandom;
      i_funct3 = 3'($urandom_range(0, 7));
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         check({tag, ".busy"}, {31'd0, o_busy}, 32'd1);
         check({tag, ".done"}, {31'd0, o_done}, (k == 3) ? 32'd1 : 32'd0);
         if (k == 3) begin
            check({tag, ".r"},  o_r, er);
            check({tag, ".nv"}, {31'd0, o_nv}, {31'd0, env});
         end
         i_op_a = $urandom;
         if (!hold) i_start = (k != 2);
      end
   endtask

   function automatic logic [31:0] pick();
      if ($urandom_range(0, 9) < 6)
         return pool[$urandom_range(0, 15)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] a, b;
      logic [2:0]  f;

      rst_n    = 1'b0;
      i_start  = 1'b0;
      i_funct3 = 3'd0;
      i_op_a   = 32'd0;
      i_op_b   = 32'd0;
      repeat (3) @(negedge clk);
      check("rst.r",    o_r, 32'd0);
      check("rst.nv",   {31'd0, o_nv}, 32'd0);
      check("rst.busy", {31'd0, o_busy}, 32'd0);
      check("rst.done", {31'd0, o_done}, 32'd0);
      rst_n = 1'b1;

      run_op("fle_1_2",      3'd0, 32'h3F800000, 32'h40000000, 1'b0);
      run_op("flt_m2_m1",    3'd1, 32'hC0000000, 32'hBF800000, 1'b0);
      run_op("flt_m1_m2",    3'd1, 32'hBF800000, 32'hC0000000, 1'b0);
      run_op("feq_zeros",    3'd2, 32'h80000000, 32'h00000000, 1'b0);
      run_op("flt_zeros",    3'd1, 32'h80000000, 32'h00000000, 1'b0);
      run_op("fle_zeros",    3'd0, 32'h00000000, 32'h80000000, 1'b0);
      run_op("feq_qnan",     3'd2, 32'h7FC00000, 32'h3F800000, 1'b0);
      run_op("fle_qnan",     3'd0, 32'h7FC00000, 32'h3F800000, 1'b0);
      run_op("feq_snan",     3'd2, 32'h7F800001, 32'h3F800000, 1'b0);
      run_op("feq_inf",      3'd2, 32'h7F800000, 32'h7F800000, 1'b0);
      run_op("flt_ninf_max", 3'd1, 32'hFF800000, 32'hFF7FFFFF, 1'b0);
      run_op("ill_qnan",     3'd5, 32'h7FC00000, 32'h7F800001, 1'b0);
      run_op("ill_eq",       3'd3, 32'h3F800000, 32'h3F800000, 1'b0);

      for (int i = 0; i < 3; i++) begin
         run_op("stream", 3'd0, pick(), pool[2], 1'b1);
      end
      i_start = 1'b0;

      run_op("pre_rst", 3'd0, 32'h3F800000, 32'h3F800000, 1'b0);
      @(negedge clk);
      i_start  = 1'b1;
      i_funct3 = 3'd1;
      i_op_a   = 32'hBF800000;
      i_op_b   = 32'h3F800000;
      @(posedge clk);
      #1 i_start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst.r",    o_r, 32'd0);
      check("midrst.nv",   {31'd0, o_nv}, 32'd0);
      check("midrst.busy", {31'd0, o_busy}, 32'd0);
      check("midrst.done", {31'd0, o_done}, 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_op("post_rst", 3'd1, 32'hBF800000, 32'h3F800000, 1'b0);

      for (int i = 0; i < 150; i++) begin
         a = pick();
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h80000000;
            default: b = pick();
         endcase
         f = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         run_op("rand", f, a, b, 1'b0);
      end
      i_start = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
